// File: rtl/interrupt_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : interrupt_controller
// Purpose  : Interrupt entry/return sequencer around decode. Define
//            INTC_ROUND_ROBIN_EN for rotating priority (fixed-lowest otherwise).
// Revision : 1.0
// ============================================================================
module interrupt_controller #(
    parameter int          NUM_IRQ      = 4,
    parameter logic [31:0] VECTOR_BASE  = 32'h0600_0100,
    parameter int          FLUSH_CYCLES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_req,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               instr_valid,
    input  logic               dec_stall,
    input  logic [4:0]         dec_opcode,
    input  logic [31:0]        dec_PC,
    input  logic [31:0]        LR,
    input  logic [1:0]         FL,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic               int_flush,
    output logic               int_pc_load,
    output logic [31:0]        int_pc,
    output logic               restore,
    output logic [31:0]        LR_before_int,
    output logic [1:0]         FL_before_int,
    output logic               in_service,
    output logic [2:0]         cur_id
);

    localparam logic [4:0] c_OP_RIN     = 5'b11111;
    localparam logic [3:0] c_FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FLUSH   = 3'd1,
        S_VECTOR  = 3'd2,
        S_SERVICE = 3'd3,
        S_RESTORE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic [31:0]         r_saved_pc;
    logic [31:0]         r_saved_lr;
    logic [1:0]          r_saved_fl;
    logic [2:0]          r_cur_id;
    logic [7:0]          w_pend;
    logic [2:0]          w_winner;
    logic                w_take;
    logic                w_rin;
    logic [NUM_IRQ-1:0]  w_ack_vec;

    assign w_pend = 8'(irq_req & ~irq_mask);
    assign w_take = (r_state == S_IDLE) & instr_valid & ~dec_stall & (|w_pend);
    assign w_rin  = instr_valid & ~dec_stall & (dec_opcode == c_OP_RIN);

`ifdef INTC_ROUND_ROBIN_EN
    logic [2:0] r_ptr;
    logic [3:0] w_idx;
    logic       w_found;

    // Search starts at the pointer and wraps modulo NUM_IRQ.
    always_comb begin
        w_winner = 3'd0;
        w_found  = 1'b0;
        w_idx    = 4'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_idx = {1'b0, r_ptr} + 4'(i);
            if (w_idx >= 4'(NUM_IRQ)) begin
                w_idx = w_idx - 4'(NUM_IRQ);
            end
            if (!w_found && w_pend[w_idx[2:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 3'd0;
        end else if (w_take) begin
            r_ptr <= (w_winner == 3'(NUM_IRQ - 1)) ? 3'd0 : w_winner + 3'd1;
        end
    end
`else
    always_comb begin
        w_winner = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (w_pend[i]) begin
                w_winner = 3'(i);
            end
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
            assign w_ack_vec[gi] = (r_cur_id == 3'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Outputs decode registered state only; irq_req reaches nothing but w_next.
    always_comb begin
        w_next      = r_state;
        irq_ack     = '0;
        int_flush   = 1'b0;
        int_pc_load = 1'b0;
        int_pc      = 32'd0;
        restore     = 1'b0;
        in_service  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_take) begin
                    w_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                int_flush = 1'b1;
                if (r_cnt == 4'd0) begin
                    irq_ack = w_ack_vec;
                end
                if (r_cnt == c_FLUSH_LAST) begin
                    w_next = S_VECTOR;
                end
            end
            S_VECTOR: begin
                int_pc_load = 1'b1;
                int_pc      = VECTOR_BASE + {25'd0, r_cur_id, 4'd0};
                w_next      = S_SERVICE;
            end
            S_SERVICE: begin
                in_service = 1'b1;
                if (w_rin) begin
                    w_next = S_RESTORE;
                end
            end
            S_RESTORE: begin
                restore     = 1'b1;
                int_flush   = 1'b1;
                int_pc_load = 1'b1;
                int_pc      = r_saved_pc;
                w_next      = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if ((r_state == S_FLUSH) && (r_cnt != c_FLUSH_LAST)) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    // The interrupted instruction is flushed, so its own PC is the return target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_saved_pc <= 32'd0;
            r_saved_lr <= 32'd0;
            r_saved_fl <= 2'd0;
            r_cur_id   <= 3'd0;
        end else if (w_take) begin
            r_saved_pc <= dec_PC;
            r_saved_lr <= LR;
            r_saved_fl <= FL;
            r_cur_id   <= w_winner;
        end
    end

    assign LR_before_int = r_saved_lr;
    assign FL_before_int = r_saved_fl;
    assign cur_id        = r_cur_id;

endmodule
`default_nettype wire
